// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioning path: default clock
// rate, debounce FSM state encoding and a ms-to-cycles helper.
package button_conditioner_pkg;

    localparam int CLK_IN_DEFAULT = 50_000_000;

    // Encodings are fixed so that downstream blocks decoding the state agree.
    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } bc_state_e;

    // Number of clock cycles in a span of milliseconds.
    // Divides first so large clock rates stay within 32 bits.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable value
// loaded on synchronous reset. Shared with the digit-entry path.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] s0_q;
    logic [WIDTH-1:0] s1_q;

    // Two register stages to resolve metastability on the raw input.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s0_q <= RESET_VAL;
            s1_q <= RESET_VAL;
        end else begin
            s0_q <= i_d;
            s1_q <= s0_q;
        end
    end

    assign o_q = s1_q;

endmodule

// File: rtl/button_conditioner.sv
// Turns one raw button level into a debounced level plus one-cycle press,
// release and long-press pulses. All outputs are registered.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CLK_IN      = CLK_IN_DEFAULT,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 2000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_level,
    output logic o_pe,
    output logic o_ne,
    output logic o_long
);

    localparam int DB_CYC   = ms_to_cycles(CLK_IN, DEBOUNCE_MS);
    localparam int LONG_CYC = ms_to_cycles(CLK_IN, LONG_MS);
    localparam int DB_W     = $clog2(DB_CYC + 1);
    localparam int LONG_W   = $clog2(LONG_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYC);

    if (DB_CYC < 1) begin : g_bad_db
        $error("button_conditioner: debounce time is shorter than one clock cycle");
    end
    if (LONG_CYC < 1) begin : g_bad_long
        $error("button_conditioner: long-press time is shorter than one clock cycle");
    end

    logic               sync_s;
    logic               raw_s;
    logic               long_fire_s;
    logic [LONG_W-1:0]  long_next_s;

    bc_state_e          state_q;
    logic [DB_W-1:0]    db_cnt_q;
    logic [LONG_W-1:0]  long_cnt_q;
    logic               level_q;
    logic               pe_q;
    logic               ne_q;
    logic               long_q;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_sig),
        .o_q     (sync_s)
    );

    // Polarity is normalised after the synchroniser so the FSM sees 1 = pressed.
    assign raw_s = sync_s ^ ACTIVE_LOW;

    // Long-hold counter step: saturates so the pulse can only fire once per press.
    always_comb begin
        long_fire_s = (long_cnt_q == LONG_LAST);
        if (long_cnt_q == LONG_MAX) begin
            long_next_s = long_cnt_q;
        end else begin
            long_next_s = long_cnt_q + LONG_W'(1);
        end
    end

    // Debounce FSM with debounce/long counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_RELEASED;
            db_cnt_q   <= '0;
            long_cnt_q <= '0;
            level_q    <= 1'b0;
            pe_q       <= 1'b0;
            ne_q       <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            pe_q   <= 1'b0;
            ne_q   <= 1'b0;
            long_q <= 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    if (raw_s) begin
                        if (DB_CYC == 1) begin
                            state_q    <= ST_HELD;
                            level_q    <= 1'b1;
                            pe_q       <= 1'b1;
                            long_cnt_q <= '0;
                            db_cnt_q   <= '0;
                        end else begin
                            state_q  <= ST_PRESS_PEND;
                            db_cnt_q <= DB_ONE;
                        end
                    end
                end
                ST_PRESS_PEND: begin
                    if (!raw_s) begin
                        state_q  <= ST_RELEASED;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= ST_HELD;
                        level_q    <= 1'b1;
                        pe_q       <= 1'b1;
                        long_cnt_q <= '0;
                        db_cnt_q   <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_ONE;
                    end
                end
                ST_HELD: begin
                    if (!raw_s && (DB_CYC == 1)) begin
                        // Immediate release: the long pulse is not allowed to coincide with o_ne.
                        state_q  <= ST_RELEASED;
                        level_q  <= 1'b0;
                        ne_q     <= 1'b1;
                        db_cnt_q <= '0;
                    end else begin
                        long_cnt_q <= long_next_s;
                        long_q     <= long_fire_s;
                        if (!raw_s) begin
                            state_q  <= ST_RELEASE_PEND;
                            db_cnt_q <= DB_ONE;
                        end
                    end
                end
                ST_RELEASE_PEND: begin
                    if (raw_s) begin
                        // Release bounce: return to HELD without restarting the long timer.
                        state_q    <= ST_HELD;
                        db_cnt_q   <= '0;
                        long_cnt_q <= long_next_s;
                        long_q     <= long_fire_s;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q  <= ST_RELEASED;
                        level_q  <= 1'b0;
                        ne_q     <= 1'b1;
                        db_cnt_q <= '0;
                    end else begin
                        db_cnt_q   <= db_cnt_q + DB_ONE;
                        long_cnt_q <= long_next_s;
                        long_q     <= long_fire_s;
                    end
                end
                default: begin
                    state_q    <= ST_RELEASED;
                    db_cnt_q   <= '0;
                    long_cnt_q <= '0;
                    level_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = level_q;
    assign o_pe    = pe_q;
    assign o_ne    = ne_q;
    assign o_long  = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: DB_CYC=10, LONG_CYC=50. One active-high and one active-low
// instance. Cycle index 0 is the step at which the stimulus edge is applied.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic sig_a, sig_b;
    logic lvl_a, pe_a, ne_a, lg_a;
    logic lvl_b, pe_b, ne_b, lg_b;

    int tests_run = 0;
    int tests_failed = 0;

    int cyc;
    int pe_n, ne_n, lg_n, lvl_n, ovl_n, pe_at, ne_at, lg_at;
    int pe2_n, ne2_n, lg2_n, lvl2_n, pe2_at, ne2_at;

    always #5 clk = ~clk;

    button_conditioner #(
        .CLK_IN(10_000), .DEBOUNCE_MS(1), .LONG_MS(5), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .i_clk(clk), .i_reset(rst), .i_sig(sig_a),
        .o_level(lvl_a), .o_pe(pe_a), .o_ne(ne_a), .o_long(lg_a)
    );

    button_conditioner #(
        .CLK_IN(10_000), .DEBOUNCE_MS(1), .LONG_MS(5), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .i_clk(clk), .i_reset(rst), .i_sig(sig_b),
        .o_level(lvl_b), .o_pe(pe_b), .o_ne(ne_b), .o_long(lg_b)
    );

    task automatic clear_stats();
        cyc = 0;
        pe_n = 0; ne_n = 0; lg_n = 0; lvl_n = 0; ovl_n = 0;
        pe_at = -1; ne_at = -1; lg_at = -1;
        pe2_n = 0; ne2_n = 0; lg2_n = 0; lvl2_n = 0;
        pe2_at = -1; ne2_at = -1;
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pe_a === 1'b1) begin pe_n++; pe_at = cyc; end
            if (ne_a === 1'b1) begin ne_n++; ne_at = cyc; end
            if (lg_a === 1'b1) begin lg_n++; lg_at = cyc; end
            if (lvl_a === 1'b1) lvl_n++;
            if ((pe_a === 1'b1) && (ne_a === 1'b1)) ovl_n++;
            if (pe_b === 1'b1) begin pe2_n++; pe2_at = cyc; end
            if (ne_b === 1'b1) begin ne2_n++; ne2_at = cyc; end
            if (lg_b === 1'b1) lg2_n++;
            if (lvl_b === 1'b1) lvl2_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sig_a = 1'b0; sig_b = 1'b1;
        step(3);
        tests_run++;
        if ({lvl_a, pe_a, ne_a, lg_a} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_a outputs got %b want 0000", {lvl_a, pe_a, ne_a, lg_a});
        end
        tests_run++;
        if ({lvl_b, pe_b, ne_b, lg_b} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_b outputs got %b want 0000", {lvl_b, pe_b, ne_b, lg_b});
        end
        rst = 1'b0;
        step(20);
    endtask

    task automatic test_clean_press();
        clear_stats();
        sig_a = 1'b1; step(30);
        sig_a = 1'b0; step(30);
        tests_run++;
        if (pe_n !== 1 || pe_at !== 12) begin
            tests_failed++;
            $display("FAIL clean_pe count=%0d at=%0d want count=1 at=12", pe_n, pe_at);
        end
        tests_run++;
        if (ne_n !== 1 || ne_at !== 42) begin
            tests_failed++;
            $display("FAIL clean_ne count=%0d at=%0d want count=1 at=42", ne_n, ne_at);
        end
        tests_run++;
        if (lvl_n !== 30) begin
            tests_failed++;
            $display("FAIL clean_level high %0d cycles want 30", lvl_n);
        end
        tests_run++;
        if (lg_n !== 0 || ovl_n !== 0) begin
            tests_failed++;
            $display("FAIL clean_long long=%0d overlap=%0d want 0 0", lg_n, ovl_n);
        end
    endtask

    task automatic test_bounce();
        clear_stats();
        for (int b = 0; b < 3; b++) begin
            sig_a = 1'b1; step(4);
            sig_a = 1'b0; step(4);
        end
        sig_a = 1'b1; step(40);
        tests_run++;
        if (pe_n !== 1 || pe_at !== 36) begin
            tests_failed++;
            $display("FAIL bounce_pe count=%0d at=%0d want count=1 at=36", pe_n, pe_at);
        end
        sig_a = 1'b0; step(20);
        tests_run++;
        if (ne_n !== 1 || ne_at !== 76 || lg_n !== 0) begin
            tests_failed++;
            $display("FAIL bounce_ne count=%0d at=%0d long=%0d want 1 76 0", ne_n, ne_at, lg_n);
        end
    endtask

    task automatic test_glitch();
        clear_stats();
        sig_a = 1'b1; step(9);
        sig_a = 1'b0; step(20);
        tests_run++;
        if (pe_n !== 0 || lvl_n !== 0 || ne_n !== 0) begin
            tests_failed++;
            $display("FAIL glitch9 pe=%0d level=%0d ne=%0d want 0 0 0", pe_n, lvl_n, ne_n);
        end
        clear_stats();
        sig_a = 1'b1; step(10);
        sig_a = 1'b0; step(30);
        tests_run++;
        if (pe_n !== 1 || pe_at !== 12) begin
            tests_failed++;
            $display("FAIL glitch10_pe count=%0d at=%0d want 1 at 12", pe_n, pe_at);
        end
        tests_run++;
        if (ne_n !== 1 || ne_at !== 22 || lvl_n !== 10) begin
            tests_failed++;
            $display("FAIL glitch10_ne count=%0d at=%0d level=%0d want 1 22 10", ne_n, ne_at, lvl_n);
        end
    endtask

    task automatic test_long_hold();
        clear_stats();
        sig_a = 1'b1; step(30);
        sig_a = 1'b0; step(5);
        sig_a = 1'b1; step(65);
        tests_run++;
        if (pe_n !== 1 || pe_at !== 12 || ne_n !== 0) begin
            tests_failed++;
            $display("FAIL long_hold_pe pe=%0d at=%0d ne=%0d want 1 12 0", pe_n, pe_at, ne_n);
        end
        tests_run++;
        if (lg_n !== 1 || lg_at !== 62) begin
            tests_failed++;
            $display("FAIL long_pulse count=%0d at=%0d want 1 at 62", lg_n, lg_at);
        end
        sig_a = 1'b0; step(20);
        tests_run++;
        if (ne_n !== 1 || ne_at !== 112 || lvl_n !== 100 || lg_n !== 1) begin
            tests_failed++;
            $display("FAIL long_release ne=%0d at=%0d level=%0d long=%0d want 1 112 100 1",
                     ne_n, ne_at, lvl_n, lg_n);
        end
    endtask

    task automatic test_reset_mid_hold();
        clear_stats();
        sig_a = 1'b1; step(40);
        tests_run++;
        if (lvl_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL midhold_level got %b want 1", lvl_a);
        end
        rst = 1'b1; step(1);
        tests_run++;
        if ({lvl_a, pe_a, ne_a, lg_a} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midhold_reset outputs got %b want 0000", {lvl_a, pe_a, ne_a, lg_a});
        end
        rst = 1'b0;
        clear_stats();
        step(20);
        tests_run++;
        if (pe_n !== 1 || pe_at !== 12) begin
            tests_failed++;
            $display("FAIL repress_pe count=%0d at=%0d want 1 at 12", pe_n, pe_at);
        end
        sig_a = 1'b0; step(20);
    endtask

    task automatic test_active_low();
        sig_b = 1'b1;
        rst = 1'b1; step(2);
        rst = 1'b0;
        clear_stats();
        step(30);
        tests_run++;
        if (pe2_n !== 0 || ne2_n !== 0 || lvl2_n !== 0 || lg2_n !== 0) begin
            tests_failed++;
            $display("FAIL al_idle pe=%0d ne=%0d level=%0d long=%0d want 0 0 0 0",
                     pe2_n, ne2_n, lvl2_n, lg2_n);
        end
        clear_stats();
        sig_b = 1'b0; step(20);
        sig_b = 1'b1; step(30);
        tests_run++;
        if (pe2_n !== 1 || pe2_at !== 12) begin
            tests_failed++;
            $display("FAIL al_pe count=%0d at=%0d want 1 at 12", pe2_n, pe2_at);
        end
        tests_run++;
        if (ne2_n !== 1 || ne2_at !== 32 || lvl2_n !== 20) begin
            tests_failed++;
            $display("FAIL al_ne count=%0d at=%0d level=%0d want 1 32 20", ne2_n, ne2_at, lvl2_n);
        end
    endtask

    initial begin
        rst = 1'b1; sig_a = 1'b0; sig_b = 1'b1;
        clear_stats();
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_hold();
        test_reset_mid_hold();
        test_active_low();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
